// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional
// parity bit (compiled in with `define UART_TX_PARITY_EN), then 1 or 2 stop bits.
module uart_tx_param #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_start,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_out
);

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int CNT_W    = $clog2(CLK_DIV);
  // Bit index 0 is the start bit; LAST_BIT is the final stop bit.
  localparam int LAST_BIT = DATA_W + PAR_BITS + STOP_BITS;
  localparam int BIT_W    = $clog2(LAST_BIT + 2);

  if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
    $error("uart_tx_param: CLK_DIV out of range");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_W out of range");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic              par_bit;
`endif

  assign baud_wrap = (baud == CNT_W'(CLK_DIV - 1));

  // NOTE: every register below is updated with <= so all reads in this block see
  // pre-edge values; blocking = here would make behaviour depend on statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it is reset
      // along with the rest for a fully defined post-reset state.
      state    <= IDLE;
      baud     <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) begin
        baud <= baud_wrap ? '0 : baud + CNT_W'(1);
        if (baud_wrap) bit_cnt <= bit_cnt + BIT_W'(1);
      end
      case (state)
        IDLE: begin
          if (tx_start) begin
            shift    <= data_in;
`ifdef UART_TX_PARITY_EN
            // Parity is captured at acceptance because the shift register is consumed.
            par_bit  <= (^data_in) ^ (PARITY_ODD != 0);
`endif
            baud     <= '0;
            bit_cnt  <= '0;
            state    <= START;
            tx_out   <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_wrap) begin
            state  <= DATA;
            tx_out <= shift[0];
          end
        end
        DATA: begin
          if (baud_wrap) begin
            shift <= shift >> 1;
            if (bit_cnt == BIT_W'(DATA_W)) begin
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_out <= par_bit;
`else
              state  <= STOP;
              tx_out <= 1'b1;
`endif
            end else begin
              tx_out <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_wrap) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_wrap && bit_cnt == BIT_W'(LAST_BIT)) begin
            state    <= IDLE;
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: two instances (8N1 @ div 4, 5-bit/2-stop @ div 3)
// with hand-computed bit patterns; expectations follow UART_TX_PARITY_EN if defined.
module tb_uart_tx_param;

  // Patterns list line levels per bit period, first bit in bit 0.
`ifdef UART_TX_PARITY_EN
  localparam logic [63:0] A_AA = 64'h554, A_07 = 64'h60E, A_55 = 64'h4AA, A_3C = 64'h478;
  localparam int          A_N  = 11;
  localparam logic [63:0] B_1F = 64'h1BE, B_07 = 64'h18E;
  localparam int          B_N  = 9;
`else
  localparam logic [63:0] A_AA = 64'h354, A_07 = 64'h20E, A_55 = 64'h2AA, A_3C = 64'h278;
  localparam int          A_N  = 10;
  localparam logic [63:0] B_1F = 64'h0FE, B_07 = 64'h0CE;
  localparam int          B_N  = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_a;
  logic [4:0] data_b;
  logic       start_a, start_b;
  logic       ready_a, busy_a, done_a, out_a;
  logic       ready_b, busy_b, done_b, out_b;
  logic       sel;
  logic       o_ready, o_busy, o_done, o_out;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(4), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(rst_n), .data_in(data_a), .tx_start(start_a),
    .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .tx_out(out_a)
  );

  uart_tx_param #(.CLK_DIV(3), .DATA_W(5), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .reset(rst_n), .data_in(data_b), .tx_start(start_b),
    .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .tx_out(out_b)
  );

  assign o_ready = sel ? ready_b : ready_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_out   = sel ? out_b   : out_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [8:0] w);
    if (sel) data_b = w[4:0];
    else     data_a = w[7:0];
  endtask

  task automatic set_start(input logic st);
    if (sel) start_b = st;
    else     start_a = st;
  endtask

  // Returns #1 after the acceptance edge.
  task automatic send(input logic s, input logic [8:0] w);
    sel = s;
    @(negedge clk);
    set_data(w);
    set_start(1'b1);
    @(posedge clk);
    #1;
  endtask

  // Samples one whole frame starting #1 after its acceptance edge, then the done pulse.
  task automatic capture(input logic [63:0] pat, input int nbits, input logic hold,
                         input logic [8:0] new_word, input string tag);
    int          div = sel ? 3 : 4;
    int          len = nbits * div;
    logic [63:0] got = '0;
    logic [63:0] exp = '0;
    logic        seen_done = 1'b0;
    check({tag, "_busy"}, o_busy, 1'b1);
    check({tag, "_ready"}, o_ready, 1'b0);
    for (int k = 0; k < len; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      got[k]    = o_out;
      exp[k]    = pat[k / div];
      seen_done = seen_done | o_done;
      if (k == 0 && !hold) set_start(1'b0);
      if (hold && k == len / 2) set_data(new_word);
    end
    check({tag, "_bits"}, got, exp);
    check({tag, "_early_done"}, seen_done, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_done"}, {o_done, o_ready, o_out}, 3'b111);
    @(posedge clk);
    #1;
    check({tag, "_after"}, {o_done, o_busy}, {1'b0, hold});
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 1'b0;
    data_a  = '0;
    data_b  = '0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", {out_a, ready_a, busy_a, done_a}, 4'b1100);
    check("reset_b", {out_b, ready_b, busy_b, done_b}, 4'b1100);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_a", {out_a, ready_a, busy_a, done_a}, 4'b1100);

    send(1'b0, 9'h0AA);
    capture(A_AA, A_N, 1'b0, 9'h0, "a_aa");
    send(1'b0, 9'h007);
    capture(A_07, A_N, 1'b0, 9'h0, "a_07");
    send(1'b1, 9'h007);
    capture(B_07, B_N, 1'b0, 9'h0, "b_07");
    send(1'b1, 9'h01F);
    capture(B_1F, B_N, 1'b0, 9'h0, "b_1f");

    // Held start: data change mid-frame must only affect the next frame.
    send(1'b0, 9'h055);
    capture(A_55, A_N, 1'b1, 9'h03C, "held1");
    capture(A_3C, A_N, 1'b0, 9'h0, "held2");

    // Abort during data bit 3 of an all-zero word, where the line is low.
    repeat (2) @(posedge clk);
    send(1'b0, 9'h000);
    set_start(1'b0);
    repeat (17) @(posedge clk);
    #1;
    check("mid_low", o_out, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort", {o_out, o_ready, o_busy, o_done}, 4'b1100);
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold", {o_out, o_done}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_idle", {o_out, o_ready, o_done}, 3'b110);
    send(1'b0, 9'h055);
    capture(A_55, A_N, 1'b0, 9'h0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
